// File: rtl/sprite_mixer_pkg.sv
// Shared types and pair-index helpers for the sprite mixer.
// Pair k(i,j), i<j, is enumerated (0,1),(0,2),..,(0,N-1),(1,2),.. in row-major order.
package sprite_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_t;

    typedef logic [11:0] rgb_t;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Row i starts after sum_{r<i}(n-1-r) = i*(2n-i-1)/2 earlier pairs.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * (2 * n - i - 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sprite_mixer_priority_encode.sv
// Combinational priority encoder: lowest set request bit wins.
module priority_encode #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scanning from the top lets the lowest index overwrite last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_mixer.sv
// Sprite layer mixer: priority colour mux with 1-cycle latency, plus per-frame
// collision statistics latched at each start_of_frame.
module sprite_mixer
    import sprite_mixer_pkg::*;
#(
    parameter int   N_LAYERS = 4,
    parameter int   WIDTH    = 640,
    parameter int   HEIGHT   = 480,
    parameter rgb_t BG_COLOR = 12'h000
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic [$clog2(WIDTH)-1:0]           pxl_x,
    input  logic [$clog2(HEIGHT)-1:0]          pxl_y,
    input  logic                               pxl_en,
    input  logic                               start_of_frame,
    input  logic [N_LAYERS-1:0]                layer_draw,
    input  logic [12*N_LAYERS-1:0]             layer_rgb,
    output logic [3:0]                         Red_level,
    output logic [3:0]                         Green_level,
    output logic [3:0]                         Blue_level,
    output logic [num_pairs(N_LAYERS)-1:0]     coll_pairs,
    output logic [15:0]                        coll_count,
    output logic [$clog2(WIDTH)-1:0]           coll_x,
    output logic [$clog2(HEIGHT)-1:0]          coll_y,
    output logic                               coll_valid
);

    localparam int NP = num_pairs(N_LAYERS);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(N_LAYERS);

    // ---------------- colour path ----------------
    logic [IW-1:0] win_idx;
    logic          win_valid;
    rgb_t          pix_rgb;
    rgb_t          rgb_q;

    priority_encode #(.N(N_LAYERS)) u_priority_encode (
        .req   (layer_draw),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        pix_rgb = BG_COLOR;
        if (pxl_en && win_valid)
            pix_rgb = layer_rgb[win_idx*12 +: 12];
    end

    // NOTE: all state uses non-blocking assignments and is cleared by the async reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rgb_q <= '0;
        else         rgb_q <= pix_rgb;
    end

    assign Red_level   = rgb_q[11:8];
    assign Green_level = rgb_q[7:4];
    assign Blue_level  = rgb_q[3:0];

    // ---------------- collision detect ----------------
    logic [NP-1:0] pair_hit;
    logic          coll_cycle;

    always_comb begin
        pair_hit = '0;
        for (int i = 0; i < N_LAYERS; i++)
            for (int j = i + 1; j < N_LAYERS; j++)
                pair_hit[pair_idx(i, j, N_LAYERS)] = layer_draw[i] & layer_draw[j];
    end

    // Two or more layers drawing is exactly "some pair is drawing".
    assign coll_cycle = pxl_en && (|pair_hit) && !start_of_frame;

    // ---------------- frame state machine ----------------
    state_t state_q, state_d;
    logic   acc_en, first_en, latch_en;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ARMED means "no collision yet this frame", so it also gates the first-hit capture.
    always_comb begin
        state_d  = state_q;
        acc_en   = 1'b0;
        first_en = 1'b0;
        latch_en = 1'b0;
        if (start_of_frame) begin
            state_d  = ARMED;
            latch_en = (state_q != IDLE);
        end else begin
            case (state_q)
                ARMED: if (coll_cycle) begin
                    state_d  = HIT;
                    acc_en   = 1'b1;
                    first_en = 1'b1;
                end
                HIT:   acc_en = coll_cycle;
                default: ;
            endcase
        end
    end

    // ---------------- accumulation ----------------
    logic [NP-1:0] acc_pairs;
    logic [15:0]   acc_count;
    logic [XW-1:0] first_x;
    logic [YW-1:0] first_y;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_pairs <= '0;
            acc_count <= '0;
            first_x   <= '0;
            first_y   <= '0;
        end else if (start_of_frame) begin
            acc_pairs <= '0;
            acc_count <= '0;
            first_x   <= '0;
            first_y   <= '0;
        end else if (acc_en) begin
            acc_pairs <= acc_pairs | pair_hit;
            if (acc_count != 16'hFFFF)
                acc_count <= acc_count + 16'd1;
            if (first_en) begin
                first_x <= pxl_x;
                first_y <= pxl_y;
            end
        end
    end

    // ---------------- latched results ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_pairs <= '0;
            coll_count <= '0;
            coll_x     <= '0;
            coll_y     <= '0;
            coll_valid <= 1'b0;
        end else begin
            coll_valid <= latch_en;
            if (latch_en) begin
                coll_pairs <= acc_pairs;
                coll_count <= acc_count;
                coll_x     <= first_x;
                coll_y     <= first_y;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mixer.sv
// Scoreboard bench for sprite_mixer (N=4, BG=12'h123): expected colours and
// latched frame records are queued as stimulus is driven and checked on output.
module tb_sprite_mixer;

    logic        clk = 1'b0;
    logic        resetN;
    logic [9:0]  pxl_x;
    logic [8:0]  pxl_y;
    logic        pxl_en;
    logic        start_of_frame;
    logic [3:0]  layer_draw;
    logic [47:0] layer_rgb;
    logic [3:0]  Red_level, Green_level, Blue_level;
    logic [5:0]  coll_pairs;
    logic [15:0] coll_count;
    logic [9:0]  coll_x;
    logic [8:0]  coll_y;
    logic        coll_valid;

    sprite_mixer #(
        .N_LAYERS (4),
        .WIDTH    (640),
        .HEIGHT   (480),
        .BG_COLOR (12'h123)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .pxl_x          (pxl_x),
        .pxl_y          (pxl_y),
        .pxl_en         (pxl_en),
        .start_of_frame (start_of_frame),
        .layer_draw     (layer_draw),
        .layer_rgb      (layer_rgb),
        .Red_level      (Red_level),
        .Green_level    (Green_level),
        .Blue_level     (Blue_level),
        .coll_pairs     (coll_pairs),
        .coll_count     (coll_count),
        .coll_x         (coll_x),
        .coll_y         (coll_y),
        .coll_valid     (coll_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  pairs;
        logic [15:0] count;
        logic [9:0]  x;
        logic [8:0]  y;
    } rec_t;

    logic [11:0] colour_q[$];
    rec_t        latch_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_armed, m_hit;
    logic [5:0]  m_pairs;
    logic [15:0] m_cnt;
    logic [9:0]  m_x;
    logic [8:0]  m_y;

    // Independent pair table: bit p is layers (pa[p], pb[p])
    int pa[6] = '{0, 0, 0, 1, 1, 2};
    int pb[6] = '{1, 2, 3, 2, 3, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pairs = '0;
        m_cnt   = '0;
        m_x     = '0;
        m_y     = '0;
        m_hit   = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] d, input logic en, input logic sof,
                       input logic [9:0] x, input logic [8:0] y, input logic chk_v = 1'b1);
        logic [11:0] exp_c;
        logic [5:0]  hits;
        logic        found, coll, exp_v;
        rec_t        r;
        layer_draw     = d;
        pxl_en         = en;
        start_of_frame = sof;
        pxl_x          = x;
        pxl_y          = y;

        exp_c = 12'h123;
        found = 1'b0;
        if (en)
            for (int i = 0; i < 4; i++)
                if (d[i] && !found) begin
                    exp_c = layer_rgb[i*12 +: 12];
                    found = 1'b1;
                end
        colour_q.push_back(exp_c);

        hits = '0;
        for (int p = 0; p < 6; p++)
            hits[p] = d[pa[p]] & d[pb[p]];
        coll  = en && ($countones(d) >= 2) && !sof;
        exp_v = 1'b0;
        if (sof) begin
            if (m_armed) begin
                r.pairs = m_pairs; r.count = m_cnt; r.x = m_x; r.y = m_y;
                latch_q.push_back(r);
                exp_v = 1'b1;
            end
            model_clear();
            m_armed = 1'b1;
        end else if (m_armed && coll) begin
            m_pairs = m_pairs | hits;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (!m_hit) begin
                m_x = x; m_y = y; m_hit = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        check("rgb", {Red_level, Green_level, Blue_level}, colour_q.pop_front());
        if (chk_v || exp_v || coll_valid)
            check("valid", coll_valid, exp_v);
        if (exp_v) begin
            r = latch_q.pop_front();
            check("pairs", coll_pairs, r.pairs);
            check("count", coll_count, r.count);
            check("x", coll_x, r.x);
            check("y", coll_y, r.y);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"},   {Red_level, Green_level, Blue_level}, 0);
        check({tag, "_pairs"}, coll_pairs, 0);
        check({tag, "_count"}, coll_count, 0);
        check({tag, "_x"},     coll_x, 0);
        check({tag, "_y"},     coll_y, 0);
        check({tag, "_valid"}, coll_valid, 0);
    endtask

    initial begin
        resetN         = 1'b0;
        pxl_x          = '0;
        pxl_y          = '0;
        pxl_en         = 1'b0;
        start_of_frame = 1'b0;
        layer_draw     = '0;
        layer_rgb      = {12'h00F, 12'h0F0, 12'hF00, 12'h0AB};
        m_armed        = 1'b0;
        model_clear();
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;

        // Frame 1 (IDLE, discarded): colour priority and background
        cyc(4'b0110, 1, 0, 10, 10);
        check("prio_direct", {Red_level, Green_level, Blue_level}, 12'hF00);
        cyc(4'b1000, 1, 0, 11, 10);
        cyc(4'b1111, 1, 0, 12, 10);
        cyc(4'b0000, 1, 0, 13, 10);
        check("bg_direct", {Red_level, Green_level, Blue_level}, 12'h123);
        cyc(4'b0001, 0, 0, 14, 10);
        check("bg_pxl_en", {Red_level, Green_level, Blue_level}, 12'h123);
        cyc(4'b1001, 1, 0, 15, 10);
        cyc(4'b1111, 1, 1, 0, 0);    // IDLE -> ARMED, no latch
        check("idle_sof_count", coll_count, 0);

        // Frame 2: directed collisions
        cyc(4'b0001, 1, 0, 99, 50);
        for (int i = 0; i < 3; i++) cyc(4'b1001, 1, 0, 100, 50);
        cyc(4'b0100, 1, 0, 150, 55);
        cyc(4'b0011, 0, 0, 160, 55);
        cyc(4'b0011, 1, 0, 200, 60);
        cyc(4'b1111, 1, 1, 300, 70); // collision on sof edge does not count
        check("f2_pairs_direct", coll_pairs, 6'b000101);
        check("f2_count_direct", coll_count, 16'd4);

        // Frame 3: clean frame
        cyc(4'b0001, 1, 0, 1, 1);
        cyc(4'b0010, 1, 0, 2, 1);
        cyc(4'b1100, 0, 0, 3, 1);
        cyc(4'b0000, 1, 0, 4, 1);
        cyc(4'b0000, 0, 1, 0, 0);
        check("clean_x_direct", coll_x, 0);

        // Frame 4: saturation (valid checked only where it could change)
        cyc(4'b1111, 1, 0, 7, 8);
        for (int i = 1; i < 70000; i++) cyc(4'b1111, 1, 0, 9, 9, 1'b0);
        cyc(4'b0000, 1, 1, 0, 0);
        check("sat_direct", coll_count, 16'hFFFF);

        // Frame 5: reset in the middle of collisions
        cyc(4'b0110, 1, 0, 20, 20);
        cyc(4'b0110, 1, 0, 21, 20);
        resetN = 1'b0;
        #2;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        check_all_zero("midrst_hold");
        resetN  = 1'b1;
        m_armed = 1'b0;
        model_clear();

        cyc(4'b0110, 1, 0, 22, 20);  // IDLE: ignored
        cyc(4'b0000, 1, 1, 0, 0);    // first sof: no latch
        check("post_rst_sof1", coll_count, 0);
        cyc(4'b0101, 1, 0, 5, 6);
        cyc(4'b0101, 1, 0, 7, 6);
        cyc(4'b0000, 1, 1, 0, 0);    // second sof: latch
        check("post_rst_pairs_direct", coll_pairs, 6'b000010);
        cyc(4'b0000, 1, 0, 0, 0);
        cyc(4'b0000, 1, 0, 0, 0);

        check("latch_q_empty", latch_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
